ping_pong_ctrl: RTL and testbench

Sequencing controller for the two-bank ping-pong buffer that bridges linear-projection output (producer) to the Qn x KnT matmul (consumer). It generates the port-A write and port-B read enables/addresses for bank 0 and bank 1, tracks per-bank full/empty state, and swaps banks so the producer fills one bank while the consumer drains the other. Optional multi-pass reads let the consumer re-read a full bank before it is released.

---
 rtl/ping_pong_ctrl_if.sv | 28 ++
 rtl/ping_pong_ctrl.sv | 178 +++++++++++++++++
 tb/tb_ping_pong_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ping_pong_ctrl_if.sv
// Producer/consumer handshake bundle for the ping-pong buffer controller.
// master = producer/consumer side, slave = controller side.
interface ping_pong_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic rd_req;
  logic out_valid;
  logic out_bank_sel;
  logic out_last;

  modport master (
    output in_valid,
    output rd_req,
    input  in_ready,
    input  out_valid,
    input  out_bank_sel,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  rd_req,
    output in_ready,
    output out_valid,
    output out_bank_sel,
    output out_last
  );
endinterface

// File: rtl/ping_pong_ctrl.sv
// Two-bank ping-pong sequencing controller: producer fills one bank while the
// consumer drains the other; banks swap on fill completion / final read pass.

// Per-bank port driver: gates enables with bank selection and parks idle
// addresses at 0 so the BRAM address pins stay quiet when unused.
module ping_pong_bank_port #(
  parameter int AW = 5
) (
  input  logic          wr_en_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic          ena_o,
  output logic [AW-1:0] addra_o,
  output logic          enb_o,
  output logic [AW-1:0] addrb_o
);
  assign ena_o   = wr_en_i;
  assign addra_o = wr_en_i ? wr_addr_i : '0;
  assign enb_o   = rd_en_i;
  assign addrb_o = rd_en_i ? rd_addr_i : '0;
endmodule

module ping_pong_ctrl #(
  parameter  int DEPTH      = 32,
  parameter  int RD_PASSES  = 1,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  ping_pong_ctrl_if.slave       bus,
  output logic                  bank0_ena,
  output logic [ADDR_WIDTH-1:0] bank0_addra,
  output logic                  bank0_enb,
  output logic [ADDR_WIDTH-1:0] bank0_addrb,
  output logic                  bank1_ena,
  output logic [ADDR_WIDTH-1:0] bank1_addra,
  output logic                  bank1_enb,
  output logic [ADDR_WIDTH-1:0] bank1_addrb,
  output logic                  active_bank_wr,
  output logic                  active_bank_rd
);
  localparam int NUM_BANKS = 2;
  localparam int STAGES    = 1;  // BRAM read latency
  localparam int PASS_W    = (RD_PASSES > 1) ? $clog2(RD_PASSES) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [PASS_W-1:0]     PASS_LAST = PASS_W'(RD_PASSES - 1);

  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [PASS_W-1:0]     pass_q, pass_d;
  logic [NUM_BANKS-1:0]  full_q, full_d;
  logic                  out_sel_q, out_sel_d;
  logic                  out_last_q, out_last_d;
  logic [STAGES:0]       vld_pipe;

  logic wr_fire, rd_fire;
  logic wr_wrap, rd_wrap, rd_release;

  // Handshake decode: write needs a non-full target, read needs a full one,
  // so the two sides can never land on the same bank in one cycle.
  assign bus.in_ready = !full_q[wr_bank_q] && !flush;
  assign wr_fire      = bus.in_valid && bus.in_ready;
  assign rd_fire      = bus.rd_req && full_q[rd_bank_q] && !flush;
  assign wr_wrap      = (wr_addr_q == ADDR_LAST);
  assign rd_wrap      = (rd_addr_q == ADDR_LAST);
  assign rd_release   = rd_wrap && (pass_q == PASS_LAST);
  assign vld_pipe[0]  = rd_fire;

  // Next-state: pointer advance, bank swap and full-flag update; flush wins.
  always_comb begin
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    pass_d     = pass_q;
    full_d     = full_q;
    out_sel_d  = rd_fire ? rd_bank_q : out_sel_q;
    out_last_d = rd_fire && rd_release;
    if (flush) begin
      wr_bank_d  = 1'b0;
      rd_bank_d  = 1'b0;
      wr_addr_d  = '0;
      rd_addr_d  = '0;
      pass_d     = '0;
      full_d     = '0;
      out_sel_d  = 1'b0;
      out_last_d = 1'b0;
    end else begin
      if (wr_fire) begin
        if (wr_wrap) begin
          wr_addr_d         = '0;
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end else begin
          wr_addr_d = wr_addr_q + 1'b1;
        end
      end
      if (rd_fire) begin
        if (rd_wrap) begin
          rd_addr_d = '0;
          if (rd_release) begin
            pass_d            = '0;
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
          end else begin
            pass_d = pass_q + 1'b1;
          end
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
    end
  end

  // State register; async reset discards any partial fill/drain progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      pass_q     <= '0;
      full_q     <= '0;
      out_sel_q  <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      pass_q     <= pass_d;
      full_q     <= full_d;
      out_sel_q  <= out_sel_d;
      out_last_q <= out_last_d;
    end
  end

  // Read-data valid tracks the BRAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe[STAGES:1] <= '0;
    else        vld_pipe[STAGES:1] <= flush ? '0 : vld_pipe[STAGES-1:0];
  end

  assign bus.out_valid    = vld_pipe[STAGES];
  assign bus.out_bank_sel = out_sel_q;
  assign bus.out_last     = out_last_q;
  assign active_bank_wr   = wr_bank_q;
  assign active_bank_rd   = rd_bank_q;

  logic [NUM_BANKS-1:0]                 ena, enb;
  logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0] addra, addrb;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    ping_pong_bank_port #(.AW(ADDR_WIDTH)) u_port (
      .wr_en_i   (wr_fire && (wr_bank_q == 1'(b))),
      .rd_en_i   (rd_fire && (rd_bank_q == 1'(b))),
      .wr_addr_i (wr_addr_q),
      .rd_addr_i (rd_addr_q),
      .ena_o     (ena[b]),
      .addra_o   (addra[b]),
      .enb_o     (enb[b]),
      .addrb_o   (addrb[b])
    );
  end

  assign bank0_ena   = ena[0];
  assign bank0_addra = addra[0];
  assign bank0_enb   = enb[0];
  assign bank0_addrb = addrb[0];
  assign bank1_ena   = ena[1];
  assign bank1_addra = addra[1];
  assign bank1_enb   = enb[1];
  assign bank1_addrb = addrb[1];
endmodule

// File: tb/tb_ping_pong_ctrl.sv
// Bench for ping_pong_ctrl: two instances (DEPTH=4, RD_PASSES=1 and 2) share
// stimulus; a word-count model predicts every enable/address/valid each cycle.
module tb_ping_pong_ctrl;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  ping_pong_ctrl_if if0 ();
  ping_pong_ctrl_if if1 ();

  logic [1:0]      ena0, enb0, ena1, enb1;
  logic [1:0][1:0] aa0, ab0, aa1, ab1;
  logic [1:0]      awr, ard;

  ping_pong_ctrl #(.DEPTH(D), .RD_PASSES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if0.slave),
    .bank0_ena(ena0[0]), .bank0_addra(aa0[0]), .bank0_enb(enb0[0]), .bank0_addrb(ab0[0]),
    .bank1_ena(ena0[1]), .bank1_addra(aa0[1]), .bank1_enb(enb0[1]), .bank1_addrb(ab0[1]),
    .active_bank_wr(awr[0]), .active_bank_rd(ard[0])
  );

  ping_pong_ctrl #(.DEPTH(D), .RD_PASSES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if1.slave),
    .bank0_ena(ena1[0]), .bank0_addra(aa1[0]), .bank0_enb(enb1[0]), .bank0_addrb(ab1[0]),
    .bank1_ena(ena1[1]), .bank1_addra(aa1[1]), .bank1_enb(enb1[1]), .bank1_addrb(ab1[1]),
    .active_bank_wr(awr[1]), .active_bank_rd(ard[1])
  );

  typedef struct packed {
    logic       rdy;
    logic       ena0;
    logic [1:0] aa0;
    logic       ena1;
    logic [1:0] aa1;
    logic       enb0;
    logic [1:0] ab0;
    logic       enb1;
    logic [1:0] ab1;
    logic       awr;
    logic       ard;
    logic       ov;
    logic       osel;
    logic       olast;
  } obs_t;

  int total = 0;
  int bad   = 0;

  // Model state: total words written / read-issued since reset or flush,
  // plus the one-cycle-delayed read-return flags.
  int   W[2];
  int   R[2];
  logic mov[2], msel[2], mlast[2];

  function automatic int passes(int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      W[k] = 0; R[k] = 0; mov[k] = 1'b0; msel[k] = 1'b0; mlast[k] = 1'b0;
    end
  endfunction

  // Banks filled = W/D, banks released = R/(D*passes); the difference is the
  // number of full banks. Word n of the stream lives in bank (n/D)%2.
  function automatic obs_t model_exp(int k, logic iv, logic rq, logic fl);
    obs_t e;
    int   fb, rb;
    logic rdy, wf, rf, wb, rbk;
    fb  = W[k] / D;
    rb  = R[k] / (D * passes(k));
    rdy = !fl && ((fb - rb) < 2);
    wf  = iv && rdy;
    rf  = rq && !fl && (fb > rb);
    wb  = 1'(fb % 2);
    rbk = 1'(rb % 2);
    e = '0;
    e.rdy = rdy;
    if (wf && !wb) begin e.ena0 = 1'b1; e.aa0 = 2'(W[k] % D); end
    if (wf &&  wb) begin e.ena1 = 1'b1; e.aa1 = 2'(W[k] % D); end
    if (rf && !rbk) begin e.enb0 = 1'b1; e.ab0 = 2'(R[k] % D); end
    if (rf &&  rbk) begin e.enb1 = 1'b1; e.ab1 = 2'(R[k] % D); end
    e.awr   = wb;
    e.ard   = rbk;
    e.ov    = mov[k];
    e.osel  = mov[k] ? msel[k]  : 1'b0;
    e.olast = mov[k] ? mlast[k] : 1'b0;
    return e;
  endfunction

  function automatic void model_step(logic iv, logic rq, logic fl);
    for (int k = 0; k < 2; k++) begin
      int fb, rb, dp;
      logic wf, rf;
      dp = D * passes(k);
      fb = W[k] / D;
      rb = R[k] / dp;
      wf = iv && !fl && ((fb - rb) < 2);
      rf = rq && !fl && (fb > rb);
      if (fl) begin
        W[k] = 0; R[k] = 0; mov[k] = 1'b0; msel[k] = 1'b0; mlast[k] = 1'b0;
      end else begin
        mov[k]   = rf;
        if (rf) msel[k] = 1'(rb % 2);
        mlast[k] = rf && ((R[k] % dp) == dp - 1);
        if (wf) W[k]++;
        if (rf) R[k]++;
      end
    end
  endfunction

  function automatic obs_t get_obs(int k);
    obs_t o;
    o = '0;
    if (k == 0) begin
      o.rdy = if0.in_ready;
      o.ena0 = ena0[0]; o.aa0 = aa0[0]; o.ena1 = ena0[1]; o.aa1 = aa0[1];
      o.enb0 = enb0[0]; o.ab0 = ab0[0]; o.enb1 = enb0[1]; o.ab1 = ab0[1];
      o.ov = if0.out_valid;
      o.osel  = if0.out_valid ? if0.out_bank_sel : 1'b0;
      o.olast = if0.out_valid ? if0.out_last : 1'b0;
    end else begin
      o.rdy = if1.in_ready;
      o.ena0 = ena1[0]; o.aa0 = aa1[0]; o.ena1 = ena1[1]; o.aa1 = aa1[1];
      o.enb0 = enb1[0]; o.ab0 = ab1[0]; o.enb1 = enb1[1]; o.ab1 = ab1[1];
      o.ov = if1.out_valid;
      o.osel  = if1.out_valid ? if1.out_bank_sel : 1'b0;
      o.olast = if1.out_valid ? if1.out_last : 1'b0;
    end
    o.awr = awr[k];
    o.ard = ard[k];
    return o;
  endfunction

  // Drive one cycle on both instances, capture observed/predicted values
  // before the edge, then advance the model across the edge.
  task automatic cycle(input logic iv, input logic rq, input logic fl,
                       output logic [35:0] o, output logic [35:0] e);
    @(negedge clk);
    if0.in_valid = iv; if1.in_valid = iv;
    if0.rd_req = rq;   if1.rd_req = rq;
    flush = fl;
    #1;
    o = {get_obs(0), get_obs(1)};
    e = {model_exp(0, iv, rq, fl), model_exp(1, iv, rq, fl)};
    @(posedge clk);
    model_step(iv, rq, fl);
  endtask

  // Assert reset asynchronously mid-cycle and capture outputs while held.
  task automatic apply_reset(output logic [35:0] o, output logic [35:0] e);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    if0.in_valid = 1'b0; if1.in_valid = 1'b0;
    if0.rd_req = 1'b0;   if1.rd_req = 1'b0;
    flush = 1'b0;
    #1;
    model_reset();
    o = {get_obs(0), get_obs(1)};
    e = {model_exp(0, 1'b0, 1'b0, 1'b0), model_exp(1, 1'b0, 1'b0, 1'b0)};
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [35:0] o, e;
    apply_reset(o, e);
    total++;
    if (o !== e) begin bad++; $display("FAIL reset got=%h want=%h", o, e); end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, 1'b0, o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL idle cyc=%0d got=%h want=%h", i, o, e); end
    end
  endtask

  task automatic test_fill();
    logic [35:0] o, e;
    apply_reset(o, e);
    for (int i = 0; i < 10; i++) begin
      cycle(i < 4, i >= 4, 1'b0, o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL fill cyc=%0d got=%h want=%h", i, o, e); end
    end
  endtask

  task automatic test_overlap();
    logic [35:0] o, e;
    apply_reset(o, e);
    for (int i = 0; i < 13; i++) begin
      cycle(i < 8, i >= 4, 1'b0, o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL overlap cyc=%0d got=%h want=%h", i, o, e); end
    end
  endtask

  task automatic test_backpressure();
    logic [35:0] o, e;
    apply_reset(o, e);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, (i >= 12) && (i < 16), 1'b0, o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL backpressure cyc=%0d got=%h want=%h", i, o, e); end
    end
  endtask

  task automatic test_multipass();
    logic [35:0] o, e;
    apply_reset(o, e);
    for (int i = 0; i < 15; i++) begin
      cycle(i < 4, i >= 4, 1'b0, o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL multipass cyc=%0d got=%h want=%h", i, o, e); end
    end
  endtask

  task automatic test_flush();
    logic [35:0] o, e;
    apply_reset(o, e);
    for (int i = 0; i < 11; i++) begin
      // 6 writes (bank 0 full, 2 into bank 1), flush with both requests up,
      // then reads that must stall because nothing is full any more.
      cycle(i <= 6, i >= 6, i == 6, o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL flush cyc=%0d got=%h want=%h", i, o, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [35:0] o, e;
    apply_reset(o, e);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, i >= 4, 1'b0, o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL pre_reset cyc=%0d got=%h want=%h", i, o, e); end
    end
    apply_reset(o, e);
    total++;
    if (o !== e) begin bad++; $display("FAIL reset_mid got=%h want=%h", o, e); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL post_reset cyc=%0d got=%h want=%h", i, o, e); end
    end
  endtask

  task automatic test_random();
    logic [35:0] o, e;
    logic iv, rq, fl;
    apply_reset(o, e);
    for (int i = 0; i < 600; i++) begin
      // Bias phases toward producer-heavy then consumer-heavy traffic.
      iv = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rq = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 79) == 0);
      cycle(iv, rq, fl, o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, o, e); end
    end
  endtask

  initial begin
    if0.in_valid = 1'b0; if1.in_valid = 1'b0;
    if0.rd_req = 1'b0;   if1.rd_req = 1'b0;
    model_reset();
    test_reset();
    test_fill();
    test_overlap();
    test_backpressure();
    test_multipass();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
